// File: rtl/kmeans_ctrl.sv
// kmeans_ctrl: frame sequencer for the k-means distance datapath.
// Streams N_PIX pixels into the datapath, tracks the in-flight strobes for
// DP_LAT cycles, and accumulates a per-cluster histogram and a distance sum.
module kmeans_ctrl #(
    parameter int N_PIX  = 64,
    parameter int DP_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        dp_clear,
    output logic        dp_c_en,
    output logic        dp_if_en,
    output logic [23:0] dp_if_in,
    input  logic [2:0]  dp_index,
    input  logic [9:0]  dp_distance,
    output logic        res_valid,
    output logic [2:0]  res_index,
    output logic [9:0]  res_distance,
    input  logic [2:0]  hist_sel,
    output logic [9:0]  hist_cnt,
    output logic [19:0] dist_sum,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]        state, state_nxt;
    logic [9:0]        acc;
    logic [DP_LAT-1:0] flight;
    logic              tap;
    logic              last_pix;
    logic [9:0]        hist [8];

    // Strobes are pure decodes of the state; the pixel handshake is combinational.
    always_comb begin
        pix_ready = (state == RUN);
        dp_if_en  = pix_valid & pix_ready;
        dp_clear  = (state == CLEAR);
        dp_c_en   = (state == LOAD);
        busy      = (state != IDLE);
        done      = (state == DONE);
        dp_if_in  = pix_data;
        hist_cnt  = hist[hist_sel];
        tap       = flight[DP_LAT-1];
        last_pix  = dp_if_en && (acc == 10'(N_PIX - 1));
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (flight == '0 && !res_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, accept counter and in-flight strobe delay line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            acc    <= '0;
            flight <= '0;
        end else begin
            state  <= state_nxt;
            flight <= (flight << 1) | DP_LAT'(dp_if_en);
            if (state == CLEAR)
                acc <= '0;
            else if (dp_if_en)
                acc <= acc + 10'd1;
        end
    end

    // Capture datapath results when a strobe emerges from the delay line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_valid    <= 1'b0;
            res_index    <= '0;
            res_distance <= '0;
        end else begin
            res_valid <= tap;
            if (tap) begin
                res_index    <= dp_index;
                res_distance <= dp_distance;
            end
        end
    end

    // Frame statistics; widths cover N_PIX<=1023 so no saturation is needed.
    always_ff @(posedge clk) begin
        if (!rst || state == CLEAR) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
            dist_sum <= '0;
        end else if (tap) begin
            hist[dp_index] <= hist[dp_index] + 10'd1;
            dist_sum       <= dist_sum + 20'(dp_distance);
        end
    end

endmodule

// File: tb/tb_kmeans_ctrl.sv
// Directed bench for kmeans_ctrl with N_PIX=4, DP_LAT=1 and a datapath model
// returning index = pixel%8, distance = 10*pixel one cycle after the strobe.
module tb_kmeans_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready, dp_clear, dp_c_en, dp_if_en;
    logic [23:0] dp_if_in;
    logic [2:0]  dp_index = '0;
    logic [9:0]  dp_distance = '0;
    logic        res_valid;
    logic [2:0]  res_index;
    logic [9:0]  res_distance;
    logic [2:0]  hist_sel;
    logic [9:0]  hist_cnt;
    logic [19:0] dist_sum;
    logic        busy, done;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_q[$];
    int res_cyc[$];
    int res_idx[$];
    int res_dst[$];

    kmeans_ctrl #(.N_PIX(4), .DP_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .dp_clear(dp_clear), .dp_c_en(dp_c_en), .dp_if_en(dp_if_en),
        .dp_if_in(dp_if_in), .dp_index(dp_index), .dp_distance(dp_distance),
        .res_valid(res_valid), .res_index(res_index), .res_distance(res_distance),
        .hist_sel(hist_sel), .hist_cnt(hist_cnt), .dist_sum(dist_sum),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: one cycle from strobe to valid result.
    always @(posedge clk) begin
        if (dp_if_en) begin
            dp_index    <= dp_if_in[2:0];
            dp_distance <= 10'(dp_if_in[9:0] * 10);
        end
    end

    // Monitor accepts, results and done pulses on the falling edge.
    always @(negedge clk) begin
        if (dp_if_en) acc_q.push_back(cyc);
        if (res_valid) begin
            res_cyc.push_back(cyc);
            res_idx.push_back(int'(res_index));
            res_dst.push_back(int'(res_distance));
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        acc_q.delete();
        res_cyc.delete();
        res_idx.delete();
        res_dst.delete();
        done_cnt = 0;
    endtask

    // Start a frame with pix_valid held high through IDLE/CLEAR/LOAD.
    task automatic start_frame(input int base);
        pix_data  = 24'(base);
        pix_valid = 1'b1;
        start     = 1'b1;
        chk("idle_ready", int'(pix_ready), 0);
        chk("idle_ifen", int'(dp_if_en), 0);
        tick();
        start = 1'b0;
        chk("seq_clear", int'(dp_clear), 1);
        chk("seq_busy", int'(busy), 1);
        tick();
        chk("seq_cen", int'(dp_c_en), 1);
        chk("load_ready", int'(pix_ready), 0);
        chk("load_ifen", int'(dp_if_en), 0);
        pix_valid = 1'b0;
        tick();
        chk("seq_ready", int'(pix_ready), 1);
    endtask

    // Feed 4 pixels base..base+3 with gap idle cycles after each; start held high.
    task automatic feed(input int base, input int gap);
        start = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pix_data  = 24'(base + p);
            pix_valid = 1'b1;
            tick();
            pix_valid = 1'b0;
            repeat (gap) tick();
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 30 && busy; k++) tick();
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic check_frame(input int base, input bit timed);
        int sum;
        int exp_h;
        sum = 0;
        chk("accepts", acc_q.size(), 4);
        chk("results", res_idx.size(), 4);
        chk("done_cnt", done_cnt, 1);
        for (int i = 0; i < 4 && i < res_idx.size(); i++) begin
            chk($sformatf("res_idx%0d", i), res_idx[i], (base + i) % 8);
            chk($sformatf("res_dst%0d", i), res_dst[i], 10 * (base + i));
            if (timed && acc_q.size() > 0)
                chk($sformatf("res_cyc%0d", i), res_cyc[i], acc_q[0] + 2 + i);
            sum += 10 * (base + i);
        end
        chk("dist_sum", int'(dist_sum), sum);
        for (int s = 0; s < 8; s++) begin
            exp_h = 0;
            for (int p = 0; p < 4; p++) if ((base + p) % 8 == s) exp_h++;
            hist_sel = 3'(s);
            #1;
            chk($sformatf("hist%0d", s), int'(hist_cnt), exp_h);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; pix_valid = 1'b1; pix_data = '0; hist_sel = '0;
        tick();
        tick();
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_clear", int'(dp_clear), 0);
        chk("rst_cen", int'(dp_c_en), 0);
        chk("rst_ifen", int'(dp_if_en), 0);
        chk("rst_rvalid", int'(res_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ridx", int'(res_index), 0);
        chk("rst_rdst", int'(res_distance), 0);
        chk("rst_sum", int'(dist_sum), 0);
        chk("rst_busy", int'(busy), 0);
        for (int s = 0; s < 8; s++) begin
            hist_sel = 3'(s);
            #1;
            chk($sformatf("rst_hist%0d", s), int'(hist_cnt), 0);
        end
        rst = 1'b1;
        tick();

        // Frame 1: continuous pixels 0..3, start held during RUN.
        clr_mon();
        start_frame(0);
        feed(0, 0);
        wait_idle();
        check_frame(0, 1'b1);

        // Frame 2: pixels 4..7 with two idle cycles between each.
        clr_mon();
        start_frame(4);
        feed(4, 2);
        wait_idle();
        check_frame(4, 1'b0);
        repeat (3) tick();
        chk("hold_sum", int'(dist_sum), 220);
        hist_sel = 3'd5;
        #1;
        chk("hold_hist5", int'(hist_cnt), 1);

        // Frame 3: reset in DRAIN with a result in flight, then a clean frame.
        clr_mon();
        start_frame(2);
        feed(2, 0);
        chk("drain_busy", int'(busy), 1);
        rst = 1'b0;
        tick();
        clr_mon();
        chk("mid_rvalid", int'(res_valid), 0);
        chk("mid_done", int'(done), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_sum", int'(dist_sum), 0);
        rst = 1'b1;
        repeat (3) tick();
        chk("mid_noresult", res_idx.size(), 0);
        chk("mid_nodone", done_cnt, 0);
        clr_mon();
        start_frame(0);
        feed(0, 0);
        wait_idle();
        check_frame(0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
